// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline, the arbiter and the unified memory.
// The slave view belongs to the arbiter; the master view belongs to the pipeline and memory side.
interface mem_arbiter_if #(
  parameter int WORD_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic                if_req;
  logic [ADDR_LEN-1:0] if_addr;
  logic [WORD_LEN-1:0] if_rdata;
  logic                if_ready;

  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [WORD_LEN-1:0] mem_rdata;
  logic                mem_ready;

  logic                ram_en;
  logic                ram_we;
  logic [ADDR_LEN-1:0] ram_addr;
  logic [WORD_LEN-1:0] ram_wdata;
  logic [WORD_LEN-1:0] ram_rdata;

  logic                freeze;

  modport slave (
    input  if_req, if_addr, MEM_R_EN, MEM_W_EN, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, freeze
  );

  modport master (
    output if_req, if_addr, MEM_R_EN, MEM_W_EN, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_en, ram_we, ram_addr, ram_wdata, freeze
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and load/store,
// data first, and produces the pipeline-wide freeze.
//
// state   | meaning
// S_IDLE  | no access in flight; arbitration cycle
// S_DATA  | load/store holding the memory port, cnt cycles left
// S_FETCH | instruction fetch holding the memory port, cnt cycles left
module mem_arbiter #(
  parameter int WORD_LEN    = 32,
  parameter int ADDR_LEN    = 32,
  parameter int MEM_LATENCY = 2
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                data_done;
  logic                if_done;
  logic                we_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [WORD_LEN-1:0] if_rdata_q;
  logic [WORD_LEN-1:0] mem_rdata_q;

  logic data_req;
  logic data_cmpl;
  logic if_cmpl;
  logic data_ok;
  logic if_ok;
  logic freeze;

  assign data_req = bus.MEM_R_EN | bus.MEM_W_EN;

  // A reset cycle never counts as a completion, so no ready escapes during reset.
  assign data_cmpl = (state == S_DATA)  && (cnt == '0) && !rst;
  assign if_cmpl   = (state == S_FETCH) && (cnt == '0) && !rst;

  assign data_ok = data_done | data_cmpl;
  assign if_ok   = if_done   | if_cmpl;
  assign freeze  = (data_req & ~data_ok) | (bus.if_req & ~if_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (data_req && !data_done) begin
            state   <= S_DATA;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            we_q    <= bus.MEM_W_EN;
            cnt     <= CNT_LOAD;
          end else if (bus.if_req && !if_done) begin
            state   <= S_FETCH;
            addr_q  <= bus.if_addr;
            wdata_q <= bus.mem_wdata;
            we_q    <= 1'b0;
            cnt     <= CNT_LOAD;
          end
        end
        S_DATA, S_FETCH: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Completion flags remember a finished port while the other one still stalls the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_done <= 1'b0;
      if_done   <= 1'b0;
    end else if (!freeze) begin
      data_done <= 1'b0;
      if_done   <= 1'b0;
    end else begin
      if (data_cmpl) data_done <= 1'b1;
      if (if_cmpl)   if_done   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (if_cmpl)             if_rdata_q  <= bus.ram_rdata;
      if (data_cmpl && !we_q)  mem_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ram_en    = (state != S_IDLE);
  assign bus.ram_we    = (state != S_IDLE) & we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

  assign bus.if_ready  = if_ok;
  assign bus.if_rdata  = if_cmpl ? bus.ram_rdata : if_rdata_q;
  // Stores complete like loads but leave the load-data register alone.
  assign bus.mem_ready = data_ok;
  assign bus.mem_rdata = (data_cmpl && !we_q) ? bus.ram_rdata : mem_rdata_q;
  assign bus.freeze    = freeze;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timing scenarios at latencies 1, 2 and 3, plus randomized
// pipeline steps on the latency-2 instance checked against a per-step timing/data model.
module tb_mem_arbiter;

  localparam int L2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] l2_last_if = 32'h0;
  logic [31:0] l2_last_ld = 32'h0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_LEN(32), .ADDR_LEN(32)) b2 ();
  mem_arbiter_if #(.WORD_LEN(32), .ADDR_LEN(32)) b1 ();
  mem_arbiter_if #(.WORD_LEN(32), .ADDR_LEN(32)) b3 ();

  mem_arbiter #(.WORD_LEN(32), .ADDR_LEN(32), .MEM_LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(b2));
  mem_arbiter #(.WORD_LEN(32), .ADDR_LEN(32), .MEM_LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.WORD_LEN(32), .ADDR_LEN(32), .MEM_LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEADBEEF;
  endfunction

  // Memory models: read data is valid only on the last cycle of an access, junk before that.
  logic [3:0] run2 = 4'd0, run1 = 4'd0, run3 = 4'd0;
  always @(posedge clk) begin
    run2 <= b2.ram_en ? run2 + 4'd1 : 4'd0;
    run1 <= b1.ram_en ? run1 + 4'd1 : 4'd0;
    run3 <= b3.ram_en ? run3 + 4'd1 : 4'd0;
  end
  assign b2.ram_rdata = (b2.ram_en && run2 == 4'd1) ? rd_fn(b2.ram_addr) : (32'hBAD0_0000 | {28'd0, run2});
  assign b1.ram_rdata = (b1.ram_en && run1 == 4'd0) ? rd_fn(b1.ram_addr) : (32'hBAD1_0000 | {28'd0, run1});
  assign b3.ram_rdata = (b3.ram_en && run3 == 4'd2) ? rd_fn(b3.ram_addr) : (32'hBAD3_0000 | {28'd0, run3});

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    b2.if_req = 1'b1; b2.if_addr = 32'h44;
    repeat (2) next_cyc;
    @(negedge clk);
    if (b2.ram_en !== 1'b0) begin n_err++; $display("FAIL reset_ram_en: got %b want 0", b2.ram_en); end n_vec++;
    if (b2.ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", b2.ram_we); end n_vec++;
    if (b2.ram_addr !== 32'h0) begin n_err++; $display("FAIL reset_ram_addr: got %h want 0", b2.ram_addr); end n_vec++;
    if (b2.ram_wdata !== 32'h0) begin n_err++; $display("FAIL reset_ram_wdata: got %h want 0", b2.ram_wdata); end n_vec++;
    if (b2.if_ready !== 1'b0) begin n_err++; $display("FAIL reset_if_ready: got %b want 0", b2.if_ready); end n_vec++;
    if (b2.mem_ready !== 1'b0) begin n_err++; $display("FAIL reset_mem_ready: got %b want 0", b2.mem_ready); end n_vec++;
    if (b2.if_rdata !== 32'h0) begin n_err++; $display("FAIL reset_if_rdata: got %h want 0", b2.if_rdata); end n_vec++;
    if (b2.mem_rdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_rdata: got %h want 0", b2.mem_rdata); end n_vec++;
    if (b2.freeze !== 1'b1) begin n_err++; $display("FAIL reset_freeze_eq: got %b want 1", b2.freeze); end n_vec++;
    next_cyc;
    rst = 1'b0; b2.if_req = 1'b0;
    @(negedge clk);
    if (b2.freeze !== 1'b0) begin n_err++; $display("FAIL reset_release_freeze: got %b want 0", b2.freeze); end n_vec++;
    if (b2.ram_en !== 1'b0) begin n_err++; $display("FAIL reset_release_en: got %b want 0", b2.ram_en); end n_vec++;
  endtask

  task automatic test_fetch;
    logic [2:0] e_en, e_fz, e_rdy;
    e_en = 3'b110; e_fz = 3'b011; e_rdy = 3'b100;
    next_cyc;
    b2.if_req = 1'b1; b2.if_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc;
      @(negedge clk);
      if (b2.ram_en !== e_en[k]) begin n_err++; $display("FAIL fetch_en c%0d: got %b want %b", k, b2.ram_en, e_en[k]); end n_vec++;
      if (b2.freeze !== e_fz[k]) begin n_err++; $display("FAIL fetch_freeze c%0d: got %b want %b", k, b2.freeze, e_fz[k]); end n_vec++;
      if (b2.if_ready !== e_rdy[k]) begin n_err++; $display("FAIL fetch_ready c%0d: got %b want %b", k, b2.if_ready, e_rdy[k]); end n_vec++;
      if (e_en[k] && b2.ram_addr !== 32'h10) begin n_err++; $display("FAIL fetch_addr c%0d: got %h want 10", k, b2.ram_addr); end n_vec++;
      if (k == 2 && b2.if_rdata !== rd_fn(32'h10)) begin n_err++; $display("FAIL fetch_rdata: got %h want %h", b2.if_rdata, rd_fn(32'h10)); end n_vec++;
    end
    l2_last_if = rd_fn(32'h10);
    next_cyc;
    b2.if_req = 1'b0;
    @(negedge clk);
    if (b2.ram_en !== 1'b0 || b2.if_ready !== 1'b0) begin n_err++; $display("FAIL fetch_after: en=%b rdy=%b want 0 0", b2.ram_en, b2.if_ready); end n_vec++;
  endtask

  task automatic test_load_fetch;
    logic [5:0] e_en, e_mrdy, e_irdy, e_fz;
    e_en = 6'b110110; e_mrdy = 6'b111100; e_irdy = 6'b100000; e_fz = 6'b011111;
    next_cyc;
    b2.if_req = 1'b1; b2.if_addr = 32'h20;
    b2.MEM_R_EN = 1'b1; b2.mem_addr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cyc;
      @(negedge clk);
      if (b2.ram_en !== e_en[k]) begin n_err++; $display("FAIL lf_en c%0d: got %b want %b", k, b2.ram_en, e_en[k]); end n_vec++;
      if (b2.ram_we !== 1'b0) begin n_err++; $display("FAIL lf_we c%0d: got %b want 0", k, b2.ram_we); end n_vec++;
      if (e_en[k] && b2.ram_addr !== ((k < 3) ? 32'h80 : 32'h20)) begin n_err++; $display("FAIL lf_addr c%0d: got %h", k, b2.ram_addr); end n_vec++;
      if (b2.mem_ready !== e_mrdy[k]) begin n_err++; $display("FAIL lf_mem_ready c%0d: got %b want %b", k, b2.mem_ready, e_mrdy[k]); end n_vec++;
      if (b2.if_ready !== e_irdy[k]) begin n_err++; $display("FAIL lf_if_ready c%0d: got %b want %b", k, b2.if_ready, e_irdy[k]); end n_vec++;
      if (b2.freeze !== e_fz[k]) begin n_err++; $display("FAIL lf_freeze c%0d: got %b want %b", k, b2.freeze, e_fz[k]); end n_vec++;
      if (k >= 2 && b2.mem_rdata !== rd_fn(32'h80)) begin n_err++; $display("FAIL lf_mem_rdata c%0d: got %h want %h", k, b2.mem_rdata, rd_fn(32'h80)); end n_vec++;
      if (k == 5 && b2.if_rdata !== rd_fn(32'h20)) begin n_err++; $display("FAIL lf_if_rdata: got %h want %h", b2.if_rdata, rd_fn(32'h20)); end n_vec++;
    end
    l2_last_ld = rd_fn(32'h80);
    l2_last_if = rd_fn(32'h20);
    next_cyc;
    b2.if_req = 1'b0; b2.MEM_R_EN = 1'b0;
    @(negedge clk);
    if (b2.mem_ready !== 1'b0 || b2.if_ready !== 1'b0 || b2.ram_en !== 1'b0) begin
      n_err++; $display("FAIL lf_flags_clear: mrdy=%b irdy=%b en=%b want 0 0 0", b2.mem_ready, b2.if_ready, b2.ram_en);
    end n_vec++;
  endtask

  task automatic test_store(input logic both);
    logic [31:0] a, d;
    a = both ? 32'h60 : 32'h40;
    d = both ? 32'hA5A5 : 32'h1234;
    next_cyc;
    b2.MEM_W_EN = 1'b1; b2.MEM_R_EN = both; b2.mem_addr = a; b2.mem_wdata = d;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cyc;
      if (k == 1) begin b2.mem_addr = 32'h44; b2.mem_wdata = 32'h5678; end
      @(negedge clk);
      if (b2.ram_we !== (k > 0)) begin n_err++; $display("FAIL st%0d_we c%0d: got %b want %b", both, k, b2.ram_we, (k > 0)); end n_vec++;
      if (k > 0 && (b2.ram_addr !== a || b2.ram_wdata !== d)) begin
        n_err++; $display("FAIL st%0d_bus c%0d: got %h/%h want %h/%h", both, k, b2.ram_addr, b2.ram_wdata, a, d);
      end n_vec++;
      if (b2.mem_ready !== (k == 2)) begin n_err++; $display("FAIL st%0d_ready c%0d: got %b want %b", both, k, b2.mem_ready, (k == 2)); end n_vec++;
      if (b2.freeze !== (k != 2)) begin n_err++; $display("FAIL st%0d_freeze c%0d: got %b want %b", both, k, b2.freeze, (k != 2)); end n_vec++;
      if (k == 2 && b2.mem_rdata !== l2_last_ld) begin n_err++; $display("FAIL st%0d_rdata: got %h want %h", both, b2.mem_rdata, l2_last_ld); end n_vec++;
    end
    next_cyc;
    b2.MEM_W_EN = 1'b0; b2.MEM_R_EN = 1'b0;
    @(negedge clk);
    if (b2.ram_we !== 1'b0 || b2.mem_ready !== 1'b0) begin n_err++; $display("FAIL st%0d_after: we=%b rdy=%b want 0 0", both, b2.ram_we, b2.mem_ready); end n_vec++;
  endtask

  task automatic test_flush;
    next_cyc;
    b2.if_req = 1'b1; b2.if_addr = 32'h30;
    next_cyc;
    b2.if_req = 1'b0;
    @(negedge clk);
    if (b2.ram_en !== 1'b1 || b2.freeze !== 1'b0) begin n_err++; $display("FAIL flush_c1: en=%b frz=%b want 1 0", b2.ram_en, b2.freeze); end n_vec++;
    next_cyc;
    @(negedge clk);
    if (b2.ram_en !== 1'b1 || b2.if_ready !== 1'b1) begin n_err++; $display("FAIL flush_c2: en=%b rdy=%b want 1 1", b2.ram_en, b2.if_ready); end n_vec++;
    if (b2.if_rdata !== rd_fn(32'h30)) begin n_err++; $display("FAIL flush_rdata: got %h want %h", b2.if_rdata, rd_fn(32'h30)); end n_vec++;
    l2_last_if = rd_fn(32'h30);
    next_cyc;
    @(negedge clk);
    if (b2.ram_en !== 1'b0 || b2.if_ready !== 1'b0) begin n_err++; $display("FAIL flush_c3: en=%b rdy=%b want 0 0", b2.ram_en, b2.if_ready); end n_vec++;
  endtask

  task automatic test_fetch_stream;
    logic [31:0] a;
    a = 32'h200;
    next_cyc;
    b1.if_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next_cyc;
      if (k % 2 == 0) begin a = 32'h200 + 32'(4 * (k / 2)); b1.if_addr = a; end
      @(negedge clk);
      if (b1.freeze !== (k % 2 == 0)) begin n_err++; $display("FAIL l1_freeze c%0d: got %b want %b", k, b1.freeze, (k % 2 == 0)); end n_vec++;
      if (b1.if_ready !== (k % 2 == 1)) begin n_err++; $display("FAIL l1_ready c%0d: got %b want %b", k, b1.if_ready, (k % 2 == 1)); end n_vec++;
      if (b1.ram_en !== (k % 2 == 1)) begin n_err++; $display("FAIL l1_en c%0d: got %b want %b", k, b1.ram_en, (k % 2 == 1)); end n_vec++;
      if (k % 2 == 1 && b1.if_rdata !== rd_fn(a)) begin n_err++; $display("FAIL l1_rdata c%0d: got %h want %h", k, b1.if_rdata, rd_fn(a)); end n_vec++;
    end
    next_cyc;
    b1.if_req = 1'b0;
  endtask

  task automatic test_random;
    int          if_r, dk, na, n_exp, n, en_cnt, we_cnt;
    logic [31:0] ia, ma, wd, first_addr, e_if, e_ld;
    bit          got_first, done;
    for (int s = 0; s < 80; s++) begin
      if_r = $urandom_range(0, 1);
      dk   = $urandom_range(0, 3);
      ia   = $urandom & 32'h0000_FFFC;
      ma   = $urandom & 32'h000F_FFFC;
      wd   = $urandom;
      next_cyc;
      b2.if_req   = (if_r == 1);
      b2.if_addr  = ia;
      b2.MEM_R_EN = (dk == 1) || (dk == 3);
      b2.MEM_W_EN = (dk >= 2);
      b2.mem_addr = ma;
      b2.mem_wdata = wd;
      na    = if_r + ((dk != 0) ? 1 : 0);
      n_exp = (na == 0) ? 1 : ((na == 1) ? L2 + 1 : 2 * L2 + 2);
      n = 0; en_cnt = 0; we_cnt = 0; got_first = 0; done = 0; first_addr = 32'h0;
      while (!done && n < 2 * L2 + 8) begin
        if (n > 0) next_cyc;
        @(negedge clk);
        n++;
        if (b2.ram_en === 1'b1) begin
          en_cnt++;
          if (!got_first) first_addr = b2.ram_addr;
          got_first = 1;
        end
        if (b2.ram_we === 1'b1) we_cnt++;
        if (b2.freeze === 1'b0) done = 1;
      end
      e_if = (if_r == 1) ? rd_fn(ia) : l2_last_if;
      e_ld = (dk == 1) ? rd_fn(ma) : l2_last_ld;
      if (!done) begin n_err++; $display("FAIL rnd%0d_timeout: freeze still 1 after %0d cycles", s, n); end n_vec++;
      if (n != n_exp) begin n_err++; $display("FAIL rnd%0d_cycles: got %0d want %0d (if=%0d dk=%0d)", s, n, n_exp, if_r, dk); end n_vec++;
      if (en_cnt != na * L2) begin n_err++; $display("FAIL rnd%0d_en_cycles: got %0d want %0d", s, en_cnt, na * L2); end n_vec++;
      if (we_cnt != ((dk >= 2) ? L2 : 0)) begin n_err++; $display("FAIL rnd%0d_we_cycles: got %0d want %0d", s, we_cnt, (dk >= 2) ? L2 : 0); end n_vec++;
      if (na > 0 && first_addr !== ((dk != 0) ? ma : ia)) begin
        n_err++; $display("FAIL rnd%0d_first_addr: got %h want %h", s, first_addr, (dk != 0) ? ma : ia);
      end n_vec++;
      if (b2.if_ready !== (if_r == 1)) begin n_err++; $display("FAIL rnd%0d_if_ready: got %b want %b", s, b2.if_ready, (if_r == 1)); end n_vec++;
      if (b2.mem_ready !== (dk != 0)) begin n_err++; $display("FAIL rnd%0d_mem_ready: got %b want %b", s, b2.mem_ready, (dk != 0)); end n_vec++;
      if (b2.if_rdata !== e_if) begin n_err++; $display("FAIL rnd%0d_if_rdata: got %h want %h", s, b2.if_rdata, e_if); end n_vec++;
      if (b2.mem_rdata !== e_ld) begin n_err++; $display("FAIL rnd%0d_mem_rdata: got %h want %h", s, b2.mem_rdata, e_ld); end n_vec++;
      l2_last_if = e_if;
      l2_last_ld = e_ld;
    end
    next_cyc;
    b2.if_req = 1'b0; b2.MEM_R_EN = 1'b0; b2.MEM_W_EN = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [5:0] e_en, e_rdy;
    e_en = 6'b111010; e_rdy = 6'b100000;
    next_cyc;
    b3.MEM_R_EN = 1'b1; b3.mem_addr = 32'h100;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cyc;
      if (k == 1) rst = 1'b1;
      if (k == 2) rst = 1'b0;
      @(negedge clk);
      if (b3.ram_en !== e_en[k]) begin n_err++; $display("FAIL rstmid_en c%0d: got %b want %b", k, b3.ram_en, e_en[k]); end n_vec++;
      if (b3.mem_ready !== e_rdy[k]) begin n_err++; $display("FAIL rstmid_ready c%0d: got %b want %b", k, b3.mem_ready, e_rdy[k]); end n_vec++;
      if (e_en[k] && b3.ram_addr !== 32'h100) begin n_err++; $display("FAIL rstmid_addr c%0d: got %h want 100", k, b3.ram_addr); end n_vec++;
      if (k == 5 && b3.mem_rdata !== rd_fn(32'h100)) begin n_err++; $display("FAIL rstmid_rdata: got %h want %h", b3.mem_rdata, rd_fn(32'h100)); end n_vec++;
    end
    next_cyc;
    b3.MEM_R_EN = 1'b0;
    @(negedge clk);
    if (b3.mem_ready !== 1'b0 || b3.ram_en !== 1'b0) begin n_err++; $display("FAIL rstmid_after: rdy=%b en=%b want 0 0", b3.mem_ready, b3.ram_en); end n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    b2.if_req = 1'b0; b2.if_addr = '0; b2.MEM_R_EN = 1'b0; b2.MEM_W_EN = 1'b0; b2.mem_addr = '0; b2.mem_wdata = '0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.MEM_R_EN = 1'b0; b1.MEM_W_EN = 1'b0; b1.mem_addr = '0; b1.mem_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.MEM_R_EN = 1'b0; b3.MEM_W_EN = 1'b0; b3.mem_addr = '0; b3.mem_wdata = '0;
    test_reset;
    test_fetch;
    test_load_fetch;
    test_store(1'b0);
    test_store(1'b1);
    test_flush;
    test_fetch_stream;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
